// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM: IDLE -> ACCESS -> RESP, gnt at N+1, ack at N+2.
// Tie-break is fixed A-over-B unless RAM_ARB_ROUND_ROBIN_EN is defined (alternating, A wins first tie after reset).
module ram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              a_gnt,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              b_gnt,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_csn,
    output logic              ram_rwn,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic                win_b_q, win_b_d;
    logic                a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
    logic                a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic                ram_csn_q, ram_csn_d, ram_rwn_q, ram_rwn_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0]   ram_din_q, ram_din_d;
    logic                busy_q, busy_d;
    logic                pick_b;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic                last_b_q, last_b_d;

    assign pick_b = b_req && (!a_req || !last_b_q);
`else
    assign pick_b = b_req && !a_req;
`endif

    // Registered outputs are computed one state ahead so they line up with the state they belong to.
    always_comb begin
        state_d    = state_q;
        win_b_d    = win_b_q;
        a_gnt_d    = 1'b0;
        b_gnt_d    = 1'b0;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        a_rdata_d  = a_rdata_q;
        b_rdata_d  = b_rdata_q;
        ram_csn_d  = 1'b1;
        ram_rwn_d  = 1'b1;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        last_b_d   = last_b_q;
`endif
        case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    state_d    = ACCESS;
                    win_b_d    = pick_b;
                    a_gnt_d    = !pick_b;
                    b_gnt_d    = pick_b;
                    ram_csn_d  = 1'b0;
                    ram_rwn_d  = pick_b ? !b_we : !a_we;
                    ram_addr_d = pick_b ? b_addr : a_addr;
                    ram_din_d  = pick_b ? b_wdata : a_wdata;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                    last_b_d   = pick_b;
`endif
                end
            end
            ACCESS: begin
                state_d = RESP;
                a_ack_d = !win_b_q;
                b_ack_d = win_b_q;
            end
            RESP: begin
                state_d = IDLE;
                if (win_b_q) begin
                    b_rdata_d = ram_dout;
                end else begin
                    a_rdata_d = ram_dout;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            win_b_q    <= 1'b0;
            a_gnt_q    <= 1'b0;
            b_gnt_q    <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            ram_csn_q  <= 1'b1;
            ram_rwn_q  <= 1'b1;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            busy_q     <= 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_b_q   <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            win_b_q    <= win_b_d;
            a_gnt_q    <= a_gnt_d;
            b_gnt_q    <= b_gnt_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            ram_csn_q  <= ram_csn_d;
            ram_rwn_q  <= ram_rwn_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            busy_q     <= busy_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_b_q   <= last_b_d;
`endif
        end
    end

    // RAM data only arrives in the RESP cycle, so the winner sees it live alongside ack, then from the hold register.
    assign a_rdata  = (state_q == RESP && !win_b_q) ? ram_dout : a_rdata_q;
    assign b_rdata  = (state_q == RESP &&  win_b_q) ? ram_dout : b_rdata_q;
    assign a_gnt    = a_gnt_q;
    assign b_gnt    = b_gnt_q;
    assign a_ack    = a_ack_q;
    assign b_ack    = b_ack_q;
    assign ram_csn  = ram_csn_q;
    assign ram_rwn  = ram_rwn_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous RAM (write returns the written data).
module tb_ram_arbiter;

    logic       clk, rst;
    logic       a_req, a_we, b_req, b_we;
    logic [3:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_gnt, a_ack, b_gnt, b_ack;
    logic [3:0] a_rdata, b_rdata;
    logic       ram_csn, ram_rwn;
    logic [3:0] ram_addr, ram_din, ram_dout;
    logic       busy;

    logic [3:0] mem [16];

    int total = 0;
    int passed = 0;
    logic [3:0] held_a, held_b;

    ram_arbiter #(.ADDR_W(4), .DATA_W(4)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_gnt(b_gnt), .b_ack(b_ack), .b_rdata(b_rdata),
        .ram_csn(ram_csn), .ram_rwn(ram_rwn), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!ram_csn) begin
            if (!ram_rwn) begin
                mem[ram_addr] <= ram_din;
                ram_dout      <= ram_din;
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    typedef struct {
        bit         is_b;
        bit         we;
        logic [3:0] addr;
        logic [3:0] wdata;
        logic [3:0] rdata;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        held_a = '0;
        held_b = '0;
    endtask

    task automatic do_txn(input string nm, input vec_t v);
        chk({nm, "_idle_busy"}, busy, 0);
        if (v.is_b) begin
            b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
        end else begin
            a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
        end
        tick();
        chk({nm, "_gnt"}, {a_gnt, b_gnt}, v.is_b ? 2'b01 : 2'b10);
        chk({nm, "_csn_rwn"}, {ram_csn, ram_rwn}, {1'b0, !v.we});
        chk({nm, "_ram_addr"}, ram_addr, v.addr);
        if (v.we) chk({nm, "_ram_din"}, ram_din, v.wdata);
        chk({nm, "_busy1"}, busy, 1);
        a_req = 1'b0;
        b_req = 1'b0;
        tick();
        chk({nm, "_ack"}, {a_ack, b_ack}, v.is_b ? 2'b01 : 2'b10);
        chk({nm, "_resp_gnt_csn"}, {a_gnt, b_gnt, ram_csn}, 3'b001);
        if (v.is_b) held_b = v.rdata;
        else        held_a = v.rdata;
        chk({nm, "_rdata"}, {a_rdata, b_rdata}, {held_a, held_b});
        chk({nm, "_busy2"}, busy, 1);
        tick();
        chk({nm, "_done"}, {busy, a_ack, b_ack, ram_csn, ram_rwn}, 5'b00011);
        chk({nm, "_rdata_hold"}, {a_rdata, b_rdata}, {held_a, held_b});
    endtask

    initial begin
        logic [3:0] exp_order;
        logic [3:0] got_order;
        int         n_gnt, n_ack, both, last_ack, cyc;

        tbl[0] = '{is_b: 1, we: 1, addr: 15, wdata: 4'h3, rdata: 4'h3};
        tbl[1] = '{is_b: 0, we: 1, addr: 5,  wdata: 4'hA, rdata: 4'hA};
        tbl[2] = '{is_b: 0, we: 0, addr: 5,  wdata: 4'h0, rdata: 4'hA};
        tbl[3] = '{is_b: 1, we: 0, addr: 15, wdata: 4'h9, rdata: 4'h3};
        tbl[4] = '{is_b: 1, we: 1, addr: 0,  wdata: 4'hC, rdata: 4'hC};
        tbl[5] = '{is_b: 0, we: 0, addr: 0,  wdata: 4'h0, rdata: 4'hC};
        tbl[6] = '{is_b: 1, we: 0, addr: 5,  wdata: 4'h0, rdata: 4'hA};
        tbl[7] = '{is_b: 0, we: 1, addr: 2,  wdata: 4'h5, rdata: 4'h5};

        for (int i = 0; i < 16; i++) mem[i] = '0;
        ram_dout = '0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        #2;
        do_reset();

        chk("reset_outputs",
            {a_gnt, a_ack, b_gnt, b_ack, ram_csn, ram_rwn, busy},
            7'b0000110);
        chk("reset_data", {a_rdata, b_rdata, ram_addr, ram_din}, 16'h0000);

        for (int i = 0; i < 8; i++) do_txn($sformatf("vec%0d", i), tbl[i]);

        // Operand capture: address changes in the grant cycle must not leak into the access.
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd2;
        tick();
        a_addr = 4'd9;
        a_req  = 1'b0;
        chk("cap_gnt", a_gnt, 1);
        chk("cap_ram_addr", ram_addr, 4'd2);
        tick();
        chk("cap_ack", a_ack, 1);
        chk("cap_rdata", a_rdata, 4'h5);
        held_a = 4'h5;
        tick();

        // Reset during ACCESS aborts: no ack, back to idle.
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 4'h7;
        tick();
        chk("rst_mid_gnt", a_gnt, 1);
        rst = 1'b1;
        a_req = 1'b0;
        tick();
        rst = 1'b0;
        held_a = '0; held_b = '0;
        chk("rst_mid_state", {a_ack, b_ack, busy, ram_csn, a_gnt}, 5'b00010);
        chk("rst_mid_rdata", {a_rdata, b_rdata}, 8'h00);
        tick();
        chk("rst_mid_noack", {a_ack, b_ack, busy}, 3'b000);
        do_txn("after_rst", '{is_b: 0, we: 1, addr: 4, wdata: 4'h6, rdata: 4'h6});

        // Tie held from reset for four accesses.
        rst = 1'b1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd5;
        b_req = 1'b1; b_we = 1'b0; b_addr = 4'd15;
        tick();
        tick();
        rst = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b1111;
`endif
        got_order = '0; n_gnt = 0; n_ack = 0; both = 0; last_ack = 0; cyc = 0;
        while (n_ack < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (a_gnt && b_gnt) both++;
            if (a_ack && b_ack) both++;
            if ((a_gnt || b_gnt) && n_gnt < 4) begin
                got_order[3 - n_gnt] = a_gnt;
                n_gnt++;
            end
            if (a_ack || b_ack) begin
                if (n_ack > 0) chk($sformatf("tie_ack_gap%0d", n_ack), cyc - last_ack, 3);
                last_ack = cyc;
                n_ack++;
            end
        end
        chk("tie_acks_seen", n_ack, 4);
        chk("tie_grant_order", got_order, exp_order);
        chk("tie_no_double", both, 0);
        a_req = 1'b0; b_req = 1'b0;
        repeat (4) tick();
        chk("tie_end_idle", busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, RAM address width.
REQ-002 Parameter DATA_W, default 4, RAM data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a_req / b_req  input  1  requester A (instruction fetch) / B (data) access request.
REQ-006 a_we / b_we  input  1  1 = write, 0 = read.
REQ-007 a_addr / b_addr  input  ADDR_W  access address.
REQ-008 a_wdata / b_wdata  input  DATA_W  write data.
REQ-009 a_gnt / b_gnt  output  1  one-cycle pulse: request accepted, operands captured.
REQ-010 a_ack / b_ack  output  1  one-cycle pulse: access complete, rdata valid.
REQ-011 a_rdata / b_rdata  output  DATA_W  read data; written data on write ack.
REQ-012 ram_csn  output  1  RAM chip select, active-low.
REQ-013 ram_rwn  output  1  RAM 1 = read, 0 = write.
REQ-014 ram_addr  output  ADDR_W  RAM address.
REQ-015 ram_din  output  DATA_W  RAM write data.
REQ-016 ram_dout  input  DATA_W  RAM registered output, valid one cycle after select.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states: IDLE, ACCESS, RESP. All outputs are registered.
REQ-019 IDLE: if any req is high, choose a winner (REQ-024), capture its we/addr/wdata, and go to ACCESS; otherwise stay in IDLE.
REQ-020 ACCESS, one cycle: ram_csn=0, ram_rwn=~we, ram_addr/ram_din = captured values; winner's gnt=1; next state RESP.
REQ-021 RESP, one cycle: ram_csn=1; winner's rdata = ram_dout; winner's ack=1; next state IDLE.
REQ-022 Latency: req first sampled high at edge N gives gnt in cycle N+1 and ack in cycle N+2. Back-to-back accesses occur every 3 cycles.
REQ-023 A requester holds req/we/addr/wdata stable until it sees gnt; changes after gnt have no effect on the current access.
REQ-024 Arbitration occurs only in IDLE. A single requester wins outright. Simultaneous requests are resolved per REQ-031/032.
REQ-025 gnt and ack are never high for both requesters in the same cycle. The loser's rdata holds its previous value.
REQ-026 Outside ACCESS: ram_csn=1, ram_rwn=1, and ram_addr/ram_din hold their last value.
REQ-027 req dropping before gnt is not supported and has no required behaviour. req held high after ack starts a new arbitration in the next IDLE cycle.

Reset
REQ-028 When rst is high at a clock edge, the next state is IDLE with: ram_csn=1, ram_rwn=1, ram_addr=0, ram_din=0, all gnt/ack=0, rdata=0, busy=0, round-robin pointer = "last served B".
REQ-029 Reset asserted in ACCESS or RESP aborts the access: no ack is issued, and a write still in flight is not re-issued.
REQ-030 rst has priority over every other input.

Configuration
REQ-031 With RAM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the requester not served last wins. The pointer updates on every grant. A wins the first tie after reset.
REQ-032 Without RAM_ARB_ROUND_ROBIN_EN: fixed priority, A always beats B, no pointer register exists, and B may starve.

Verification
REQ-033 Write then read: A writes addr 5 = 0xA, then reads addr 5 -> a_gnt at N+1 with ram_csn=0 and ram_rwn=0; a_ack at N+2; read a_rdata=0xA.
REQ-034 Tie with round-robin enabled: a_req and b_req held high from reset for 4 accesses -> grant order A,B,A,B, with acks 3 cycles apart.
REQ-035 Tie with macro absent: same stimulus -> grant order A,A,A,A, and b_gnt never asserts.
REQ-036 Lone B: B writes addr 15 = 0x3 -> b_ack with b_rdata=0x3; A outputs stay 0; busy is high for exactly 2 cycles.
REQ-037 Reset mid-access: rst high during ACCESS -> next cycle IDLE, ram_csn=1, no ack, busy=0; the next request completes normally.
REQ-038 Operand capture: A changes a_addr from 2 to 9 in the gnt cycle -> ram_addr=2 for that access.
